// File: rtl/sync_mem_bank_if.sv
// Request/response bus between the load/store unit and sync_mem_bank.
// The master issues requests; the slave (memory) returns read responses.
interface sync_mem_bank_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;
   logic                  init_done;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );
endinterface

// File: rtl/sync_mem_bank.sv
// Clocked single-port data memory with byte enables, 1- or 2-cycle read latency
// and a self-initialising INIT phase that writes every word after reset.
module sync_mem_bank #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int DEPTH     = 32,
   parameter int READ_LAT  = 1,
   parameter int INIT_MODE = 1
) (
   input logic          clk,
   input logic          rst,
   sync_mem_bank_if.slave bus
);
   localparam int                BE_W     = DATA_W / 8;
   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] init_cnt;
   logic              init_done_r;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              in_range;
   logic              wr_acc;
   logic              rd_acc;
   logic [IDX_W-1:0]  idx;

   logic              vld_p0;
   logic [DATA_W-1:0] rdata_p0;
   logic              err_p0;

   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_w,
      input logic [DATA_W-1:0] new_w,
      input logic [BE_W-1:0]   be
   );
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int k = 0; k < BE_W; k++) begin
         if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
      end
      return res;
   endfunction

   function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
      return (INIT_MODE != 0) ? DATA_W'(a) : '0;
   endfunction

   // Ready drops in the reset cycle too, so nothing is accepted on the edge rst wins.
   assign bus.req_ready = (state == ST_RUN) && !rst;
   assign bus.init_done = init_done_r;

   assign accept   = bus.req_valid && bus.req_ready;
   assign in_range = {1'b0, bus.req_addr} < DEPTH_L;
   assign idx      = bus.req_addr[IDX_W-1:0];
   assign wr_acc   = accept && bus.req_we && in_range;
   assign rd_acc   = accept && !bus.req_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_INIT;
         init_cnt    <= '0;
         init_done_r <= 1'b0;
      end else if (state == ST_INIT) begin
         if (init_cnt == LAST_IDX) begin
            state       <= ST_RUN;
            init_done_r <= 1'b1;
         end else begin
            init_cnt <= init_cnt + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_INIT) begin
            mem[init_cnt[IDX_W-1:0]] <= init_word(init_cnt);
         end else if (wr_acc) begin
            mem[idx] <= merge_bytes(mem[idx], bus.req_wdata, bus.req_be);
         end
      end
   end

   // Stage p0: array read at the accepting edge; data held until the next read
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0   <= 1'b0;
         rdata_p0 <= '0;
         err_p0   <= 1'b0;
      end else begin
         vld_p0 <= rd_acc;
         if (rd_acc) begin
            rdata_p0 <= in_range ? mem[idx] : '0;
            err_p0   <= !in_range;
         end
      end
   end

   generate
      if (READ_LAT >= 2) begin : g_lat2
         logic              vld_p1;
         logic [DATA_W-1:0] rdata_p1;
         logic              err_p1;

         // Stage p1: extra response register for the two-cycle latency build
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_p1   <= 1'b0;
               rdata_p1 <= '0;
               err_p1   <= 1'b0;
            end else begin
               vld_p1 <= vld_p0;
               if (vld_p0) begin
                  rdata_p1 <= rdata_p0;
                  err_p1   <= err_p0;
               end
            end
         end

         assign bus.rsp_valid = vld_p1;
         assign bus.rsp_rdata = rdata_p1;
         assign bus.rsp_err   = err_p1;
      end else begin : g_lat1
         assign bus.rsp_valid = vld_p0;
         assign bus.rsp_rdata = rdata_p0;
         assign bus.rsp_err   = err_p0;
      end
   endgenerate
endmodule

// File: tb/tb_sync_mem_bank.sv
// Bench for sync_mem_bank: two instances (32 words / latency 1, 20 words / latency 2)
// share one request stream and are compared every cycle against an array-based model.
module tb_sync_mem_bank;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;

   always #5 clk = ~clk;

   sync_mem_bank_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
   sync_mem_bank_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

   assign ifa.req_valid = req_valid;
   assign ifa.req_we    = req_we;
   assign ifa.req_addr  = req_addr;
   assign ifa.req_wdata = req_wdata;
   assign ifa.req_be    = req_be;
   assign ifb.req_valid = req_valid;
   assign ifb.req_we    = req_we;
   assign ifb.req_addr  = req_addr;
   assign ifb.req_wdata = req_wdata;
   assign ifb.req_be    = req_be;

   sync_mem_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .READ_LAT(1), .INIT_MODE(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa.slave)
   );
   sync_mem_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(20), .READ_LAT(2), .INIT_MODE(1)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb.slave)
   );

   logic        g_rdy  [2];
   logic        g_done [2];
   logic        g_vld  [2];
   logic        g_err  [2];
   logic [31:0] g_dat  [2];

   assign g_rdy[0]  = ifa.req_ready;
   assign g_done[0] = ifa.init_done;
   assign g_vld[0]  = ifa.rsp_valid;
   assign g_err[0]  = ifa.rsp_err;
   assign g_dat[0]  = ifa.rsp_rdata;
   assign g_rdy[1]  = ifb.req_ready;
   assign g_done[1] = ifb.init_done;
   assign g_vld[1]  = ifb.rsp_valid;
   assign g_err[1]  = ifb.rsp_err;
   assign g_dat[1]  = ifb.rsp_rdata;

   // Reference model: word array, init countdown, and expected responses keyed by due cycle
   logic [31:0] mdl    [2][32];
   int          init_left [2];
   bit          pv     [2][8];
   logic [31:0] pd     [2][8];
   bit          pe     [2][8];
   logic [31:0] last_d [2];
   bit          last_e [2];
   int          cyc;
   int          n_cmp;
   int          n_bad;

   typedef struct {
      bit          we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_a;
      bit          err_a;
      logic [31:0] exp_b;
      bit          err_b;
   } vec_t;

   vec_t tbl [20];

   function automatic int dep(input int k);
      return (k == 0) ? 32 : 20;
   endfunction

   function automatic int lat(input int k);
      return (k == 0) ? 1 : 2;
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s dut=%s cyc=%0d got=%h exp=%h", nm, (k == 0) ? "A" : "B", cyc, got, exp);
      end
   endtask

   task automatic model_reset(input int k);
      init_left[k] = dep(k);
      for (int i = 0; i < 32; i++) mdl[k][i] = (i < dep(k)) ? 32'(i) : 32'h0;
      for (int s = 0; s < 8; s++) pv[k][s] = 1'b0;
      last_d[k] = 32'h0;
      last_e[k] = 1'b0;
   endtask

   task automatic step(input bit r, input bit v, input bit we, input logic [4:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input bit ov,
                       input logic [31:0] ea, input bit eea, input logic [31:0] eb, input bit eeb);
      bit          acc;
      int          slot;
      logic [31:0] d;
      bit          e;
      rst       = r;
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      req_be    = be;
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            model_reset(k);
         end else begin
            acc = v && (init_left[k] == 0);
            if (init_left[k] > 0) init_left[k]--;
            if (acc && we && (int'(a) < dep(k))) begin
               for (int b = 0; b < 4; b++)
                  if (be[b]) mdl[k][a][8*b +: 8] = wd[8*b +: 8];
            end
            if (acc && !we) begin
               if (ov) begin
                  d = (k == 0) ? ea : eb;
                  e = (k == 0) ? eea : eeb;
               end else begin
                  e = (int'(a) >= dep(k));
                  d = e ? 32'h0 : mdl[k][a];
               end
               slot = (cyc + lat(k) - 1) % 8;
               pv[k][slot] = 1'b1;
               pd[k][slot] = d;
               pe[k][slot] = e;
            end
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         slot = cyc % 8;
         chk("req_ready", k, 32'(g_rdy[k]), 32'((init_left[k] == 0) && !r));
         chk("init_done", k, 32'(g_done[k]), 32'(init_left[k] == 0));
         chk("rsp_valid", k, 32'(g_vld[k]), 32'(pv[k][slot]));
         if (pv[k][slot]) begin
            last_d[k]   = pd[k][slot];
            last_e[k]   = pe[k][slot];
            pv[k][slot] = 1'b0;
         end
         chk("rsp_rdata", k, g_dat[k], last_d[k]);
         chk("rsp_err", k, 32'(g_err[k]), 32'(last_e[k]));
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit r);
      step(r, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic wait_init();
      for (int i = 0; i < 40 && (init_left[0] != 0 || init_left[1] != 0); i++) idle(1'b0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      cyc   = 0;
      tbl[0]  = '{1'b0, 5'd1,  32'h0,        4'h0, 32'd1,        1'b0, 32'd1,        1'b0};
      tbl[1]  = '{1'b0, 5'd2,  32'h0,        4'h0, 32'd2,        1'b0, 32'd2,        1'b0};
      tbl[2]  = '{1'b0, 5'd3,  32'h0,        4'h0, 32'd3,        1'b0, 32'd3,        1'b0};
      tbl[3]  = '{1'b0, 5'd5,  32'h0,        4'h0, 32'd5,        1'b0, 32'd5,        1'b0};
      tbl[4]  = '{1'b0, 5'd31, 32'h0,        4'h0, 32'd31,       1'b0, 32'h0,        1'b1};
      tbl[5]  = '{1'b1, 5'd3,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[6]  = '{1'b1, 5'd3,  32'h000000AA, 4'h1, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[7]  = '{1'b0, 5'd3,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 32'hDEADBEAA, 1'b0};
      tbl[8]  = '{1'b1, 5'd25, 32'h00000055, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[9]  = '{1'b0, 5'd25, 32'h0,        4'h0, 32'h00000055, 1'b0, 32'h0,        1'b1};
      tbl[10] = '{1'b0, 5'd19, 32'h0,        4'h0, 32'd19,       1'b0, 32'd19,       1'b0};
      tbl[11] = '{1'b1, 5'd7,  32'h00001234, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[12] = '{1'b0, 5'd7,  32'h0,        4'h0, 32'h00001234, 1'b0, 32'h00001234, 1'b0};
      tbl[13] = '{1'b0, 5'd7,  32'h0,        4'h0, 32'h00001234, 1'b0, 32'h00001234, 1'b0};
      tbl[14] = '{1'b1, 5'd7,  32'h0000BEEF, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[15] = '{1'b1, 5'd10, 32'h11223344, 4'h6, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[16] = '{1'b0, 5'd10, 32'h0,        4'h0, 32'h0022330A, 1'b0, 32'h0022330A, 1'b0};
      tbl[17] = '{1'b1, 5'd4,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[18] = '{1'b0, 5'd4,  32'h0,        4'h0, 32'd4,        1'b0, 32'd4,        1'b0};
      tbl[19] = '{1'b0, 5'd7,  32'h0,        4'h0, 32'h0000BEEF, 1'b0, 32'h0000BEEF, 1'b0};

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = '0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) idle(1'b1);
      wait_init();

      for (int i = 0; i < 20; i++)
         step(1'b0, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, !tbl[i].we,
              tbl[i].exp_a, tbl[i].err_a, tbl[i].exp_b, tbl[i].err_b);
      idle(1'b0);
      idle(1'b0);

      // Reset lands one cycle after a read: the latency-2 response must never appear
      step(1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 1'b1, 32'h0000BEEF, 1'b0, 32'h0000BEEF, 1'b0);
      idle(1'b1);
      idle(1'b0);
      wait_init();
      step(1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 1'b1, 32'd7, 1'b0, 32'd7, 1'b0);
      idle(1'b0);
      idle(1'b0);

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
              1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      end
      for (int i = 0; i < 3; i++) idle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
